lru_update_ctrl: RTL and testbench

//  Owns the per-set 4-way tree-PLRU state of the cache and sequences every access to it.

---
 rtl/lru_update_ctrl.sv | 153 +++++++++++++++
 tb/tb_lru_update_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lru_update_ctrl.sv
// Per-set 4-way tree-PLRU state with fill/hit touch arbitration, registered victim lookup and invalidate sweep.
// Optional statistics counters are compiled in with `define LRU_STATS_EN.
module lru_update_ctrl #(
   parameter int NUM_SETS = 16,
   parameter int STAT_W   = 16,
   localparam int SET_W   = $clog2(NUM_SETS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fill_valid,
   output logic             fill_ready,
   input  logic [SET_W-1:0] fill_set,
   input  logic [1:0]       fill_way,
   input  logic             hit_valid,
   output logic             hit_ready,
   input  logic [SET_W-1:0] hit_set,
   input  logic [1:0]       hit_way,
   input  logic             victim_req,
   output logic             victim_ready,
   input  logic [SET_W-1:0] victim_set,
   output logic             victim_valid,
   output logic [1:0]       victim_way,
   input  logic             inv_req,
   output logic             busy,
   output logic             inv_done
`ifdef LRU_STATS_EN
  ,output logic [STAT_W-1:0] stat_fill,
   output logic [STAT_W-1:0] stat_hit,
   output logic [STAT_W-1:0] stat_victim
`endif
);

   if (NUM_SETS < 2 || (NUM_SETS & (NUM_SETS - 1)) != 0 || STAT_W < 1) begin : g_bad_cfg
      $error("lru_update_ctrl: NUM_SETS must be a power of two >= 2 and STAT_W >= 1");
   end

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t           state_q, state_d;
   logic [SET_W-1:0] cnt_q, cnt_d;
   logic             inv_pend_q, inv_pend_d;
   logic             inv_done_q, inv_done_d;
   logic             victim_valid_q;
   logic [1:0]       victim_way_q;
   logic [2:0]       lru_q [NUM_SETS];
   logic [2:0]       lru_d [NUM_SETS];
   logic             fill_acc, hit_acc, victim_acc, sweep_start;

   function automatic logic [2:0] touch(input logic [2:0] s, input logic [1:0] w);
      logic [2:0] r;
      r = s;
      r[0] = ~w[1];
      if (w[1]) r[2] = ~w[0];
      else      r[1] = ~w[0];
      return r;
   endfunction

   function automatic logic [1:0] decode(input logic [2:0] s);
      return s[0] ? {1'b1, s[2]} : {1'b0, s[1]};
   endfunction

   assign fill_ready   = (state_q == IDLE);
   assign hit_ready    = (state_q == IDLE) && !(fill_valid && (fill_set == hit_set));
   assign victim_ready = (state_q == IDLE);
   assign busy         = (state_q == SWEEP);
   assign fill_acc     = fill_valid && fill_ready;
   assign hit_acc      = hit_valid && hit_ready;
   assign victim_acc   = victim_req && victim_ready;
   assign victim_valid = victim_valid_q;
   assign victim_way   = victim_way_q;
   assign inv_done     = inv_done_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      inv_pend_d  = inv_pend_q;
      inv_done_d  = 1'b0;
      sweep_start = 1'b0;
      lru_d       = lru_q;
      case (state_q)
         IDLE: begin
            // Fill and hit accepted together always target different sets.
            if (fill_acc) lru_d[fill_set] = touch(lru_q[fill_set], fill_way);
            if (hit_acc)  lru_d[hit_set]  = touch(lru_q[hit_set], hit_way);
            if (inv_req || inv_pend_q) begin
               if (fill_acc || hit_acc) begin
                  inv_pend_d = 1'b1;
               end else begin
                  inv_pend_d  = 1'b0;
                  state_d     = SWEEP;
                  cnt_d       = '0;
                  sweep_start = 1'b1;
               end
            end
         end
         SWEEP: begin
            lru_d[cnt_q] = 3'b000;
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == SET_W'(NUM_SETS - 1)) begin
               state_d    = IDLE;
               inv_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         inv_pend_q     <= 1'b0;
         inv_done_q     <= 1'b0;
         victim_valid_q <= 1'b0;
         victim_way_q   <= 2'd0;
         for (int i = 0; i < NUM_SETS; i++) lru_q[i] <= 3'b000;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         inv_pend_q     <= inv_pend_d;
         inv_done_q     <= inv_done_d;
         victim_valid_q <= victim_acc;
         // lru_d already carries this cycle's touches, giving same-cycle forwarding.
         if (victim_acc) victim_way_q <= decode(lru_d[victim_set]);
         for (int i = 0; i < NUM_SETS; i++) lru_q[i] <= lru_d[i];
      end
   end

`ifdef LRU_STATS_EN
   logic [STAT_W-1:0] stat_fill_q, stat_hit_q, stat_victim_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_fill_q   <= '0;
         stat_hit_q    <= '0;
         stat_victim_q <= '0;
      end else if (sweep_start) begin
         stat_fill_q   <= '0;
         stat_hit_q    <= '0;
         stat_victim_q <= '0;
      end else begin
         if (fill_acc && !(&stat_fill_q))     stat_fill_q   <= stat_fill_q + 1'b1;
         if (hit_acc && !(&stat_hit_q))       stat_hit_q    <= stat_hit_q + 1'b1;
         if (victim_acc && !(&stat_victim_q)) stat_victim_q <= stat_victim_q + 1'b1;
      end
   end

   assign stat_fill   = stat_fill_q;
   assign stat_hit    = stat_hit_q;
   assign stat_victim = stat_victim_q;
`endif

endmodule

// File: tb/tb_lru_update_ctrl.sv
// Directed bench for lru_update_ctrl; victim results are checked against a queue of expected ways.
module tb_lru_update_ctrl;
   localparam int NS = 16;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fill_valid = 0, hit_valid = 0, victim_req = 0, inv_req = 0;
   logic [SW-1:0] fill_set = 0, hit_set = 0, victim_set = 0;
   logic [1:0]    fill_way = 0, hit_way = 0;
   logic          fill_ready, hit_ready, victim_ready, victim_valid, busy, inv_done;
   logic [1:0]    victim_way;
`ifdef LRU_STATS_EN
   logic [15:0]   stat_fill, stat_hit, stat_victim;
`endif

   int total = 0;
   int bad = 0;
   logic [1:0] exp_q [$];

   lru_update_ctrl #(.NUM_SETS(NS), .STAT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_set(fill_set), .fill_way(fill_way),
      .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_set(hit_set), .hit_way(hit_way),
      .victim_req(victim_req), .victim_ready(victim_ready), .victim_set(victim_set),
      .victim_valid(victim_valid), .victim_way(victim_way),
      .inv_req(inv_req), .busy(busy), .inv_done(inv_done)
`ifdef LRU_STATS_EN
     ,.stat_fill(stat_fill), .stat_hit(stat_hit), .stat_victim(stat_victim)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: every victim_valid pulse consumes one expected way.
   always @(negedge clk) begin
      if (rst_n && victim_valid) begin
         if (exp_q.size() == 0) begin
            chk("victim_unexpected", 32'(victim_valid), 32'd0);
         end else begin
            logic [1:0] e;
            e = exp_q.pop_front();
            chk("victim_way", 32'(victim_way), 32'(e));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [SW-1:0] s, input logic [1:0] e);
      victim_req = 1; victim_set = s;
      exp_q.push_back(e);
      step();
      victim_req = 0;
   endtask

   task automatic fill(input logic [SW-1:0] s, input logic [1:0] w);
      fill_valid = 1; fill_set = s; fill_way = w;
      step();
      fill_valid = 0;
   endtask

   task automatic hit(input logic [SW-1:0] s, input logic [1:0] w);
      hit_valid = 1; hit_set = s; hit_way = w;
      step();
      hit_valid = 0;
   endtask

   initial begin
      int busy_cnt;
      bit done_seen;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_victim_valid", 32'(victim_valid), 0);
      chk("rst_victim_way", 32'(victim_way), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_inv_done", 32'(inv_done), 0);
      chk("rst_fill_ready", 32'(fill_ready), 1);
      @(posedge clk); #1; rst_n = 1;
      step();

      // 1: fresh state -> way 0
      lookup(5, 2'd0);
      step();

      // 2: fill way0 -> victim 2; hit way2 -> victim 1
      fill(5, 2'd0);
      lookup(5, 2'd2);
      hit(5, 2'd2);
      lookup(5, 2'd1);

      // 3: same-set fill and hit: hit stalls one cycle, then commits
      fill_valid = 1; fill_set = 3; fill_way = 0;
      hit_valid = 1; hit_set = 3; hit_way = 2;
      #1;
      chk("same_set_hit_ready", 32'(hit_ready), 0);
      chk("same_set_fill_ready", 32'(fill_ready), 1);
      step();
      fill_valid = 0;
      #1;
      chk("stalled_hit_ready", 32'(hit_ready), 1);
      step();
      hit_valid = 0;
      lookup(3, 2'd1);
      // different sets are accepted together
      fill_valid = 1; fill_set = 9; fill_way = 1;
      hit_valid = 1; hit_set = 10; hit_way = 0;
      #1;
      chk("diff_set_hit_ready", 32'(hit_ready), 1);
      step();
      fill_valid = 0; hit_valid = 0;
      lookup(9, 2'd2);
      lookup(10, 2'd2);

      // 4: forwarding of same-cycle touches into the lookup
      hit_valid = 1; hit_set = 7; hit_way = 1;
      victim_req = 1; victim_set = 7; exp_q.push_back(2'd2);
      step();
      hit_valid = 0; victim_req = 0;
      fill_valid = 1; fill_set = 11; fill_way = 0;
      victim_req = 1; victim_set = 11; exp_q.push_back(2'd2);
      step();
      fill_valid = 0; victim_req = 0;
      step();
`ifdef LRU_STATS_EN
      chk("stat_fill", 32'(stat_fill), 4);
      chk("stat_hit", 32'(stat_hit), 4);
      chk("stat_victim", 32'(stat_victim), 8);
`endif

      // 5: inv_req with a concurrent fill: fill first, sweep one cycle later
      fill_valid = 1; fill_set = 12; fill_way = 0;
      inv_req = 1;
      step();
      fill_valid = 0; inv_req = 0;
      @(negedge clk);
      chk("sweep_deferred", 32'(busy), 0);
      busy_cnt = 0; done_seen = 0;
      for (int i = 0; i < 40 && !done_seen; i++) begin
         @(negedge clk);
         if (busy) begin
            busy_cnt++;
            if (busy_cnt == 1) begin
               chk("sweep_fill_ready", 32'(fill_ready), 0);
               chk("sweep_victim_ready", 32'(victim_ready), 0);
               fill_valid = 1; fill_set = 5; fill_way = 2;
               hit_valid = 1; hit_set = 3; hit_way = 0;
               victim_req = 1; victim_set = 5;
            end
            if (busy_cnt == 2) chk("sweep_hit_ready", 32'(hit_ready), 0);
            if (busy_cnt == NS - 1) begin
               fill_valid = 0; hit_valid = 0; victim_req = 0;
            end
         end
         if (inv_done) begin
            done_seen = 1;
            chk("done_busy_low", 32'(busy), 0);
         end
      end
      chk("inv_done_seen", 32'(done_seen), 1);
      chk("sweep_len", 32'(busy_cnt), NS);
      @(negedge clk);
      chk("inv_done_pulse", 32'(inv_done), 0);
      @(posedge clk); #1;
      lookup(5, 2'd0);
      lookup(3, 2'd0);
      lookup(7, 2'd0);
      lookup(12, 2'd0);

      // 6: reset during sweep cycle 8
      fill_valid = 1; fill_set = 15; fill_way = 0;
      hit_valid = 1; hit_set = 14; hit_way = 1;
      step();
      fill_valid = 0; hit_valid = 0;
      lookup(15, 2'd2);
      inv_req = 1;
      step();
      inv_req = 0;
      busy_cnt = 0;
      for (int i = 0; i < 40 && busy_cnt < 9; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      chk("pre_abort_busy_cycles", 32'(busy_cnt), 9);
      rst_n = 0;
      #1;
      chk("abort_busy", 32'(busy), 0);
      done_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (inv_done) done_seen = 1;
      end
      @(posedge clk); #1; rst_n = 1;
      repeat (NS + 2) begin
         @(negedge clk);
         if (inv_done) done_seen = 1;
      end
      chk("abort_no_done", 32'(done_seen), 0);
      chk("abort_idle", 32'(fill_ready), 1);
`ifdef LRU_STATS_EN
      chk("abort_stat_fill", 32'(stat_fill), 0);
      chk("abort_stat_hit", 32'(stat_hit), 0);
      chk("abort_stat_victim", 32'(stat_victim), 0);
`endif
      @(posedge clk); #1;
      lookup(15, 2'd0);
      lookup(14, 2'd0);
      lookup(5, 2'd0);
      repeat (3) step();

      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
